// File: rtl/password_entry_pkg.sv
// Shared types and key-code constants for the password_entry keypad front end.
package password_entry_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_READY   = 2'd2,
      ST_LOCKED  = 2'd3
   } pe_state_t;

   localparam logic [3:0] KEY_CLEAR = 4'hA;
   localparam logic [3:0] KEY_BKSP  = 4'hB;
   localparam logic [3:0] KEY_ENTER = 4'hE;

   function automatic logic is_digit(input logic [3:0] code);
      return (code <= 4'd9);
   endfunction

endpackage

// File: rtl/entry_timer.sv
// Down-counting cycle timer: start (or kick while running) reloads, expire flags
// the CYCLES-th consecutive cycle without a kick.
module entry_timer #(
   parameter int CYCLES = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic start_i,
   input  logic kick_i,
   output logic expire_o
);

   localparam int            W      = $clog2(CYCLES + 1);
   localparam logic [W-1:0]  RELOAD = W'(CYCLES - 1);

   logic [W-1:0] cnt_q, cnt_d;
   logic         run_q, run_d;

   always_comb begin
      cnt_d    = cnt_q;
      run_d    = run_q;
      expire_o = run_q && (cnt_q == '0) && !kick_i;
      if (start_i || (run_q && kick_i)) begin
         cnt_d = RELOAD;
         run_d = 1'b1;
      end else if (run_q) begin
         if (cnt_q == '0) begin
            run_d = 1'b0;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

endmodule

// File: rtl/password_entry.sv
// Keypad front end: collects four BCD digits, hands a held password to the gate
// FSM and locks the keypad out after repeated rejections.
module password_entry
   import password_entry_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int MAX_TRIES      = 3,
   parameter int LOCK_CYCLES    = 5000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        arm_i,
   input  logic        key_valid_i,
   input  logic [3:0]  key_code_i,
   input  logic        pw_ok_i,
   input  logic        pw_wrong_i,
   output logic [15:0] password_o,
   output logic        pw_valid_o,
   output logic        entry_active_o,
   output logic        locked_o,
   output logic [2:0]  digit_count_o
);

   // state   | meaning
   // IDLE    | no car; buffer cleared, waiting for arm
   // COLLECT | taking digits and edit keys, idle timeout running
   // READY   | password presented, waiting for gate verdict
   // LOCKED  | too many rejections; everything ignored until lock timer ends

   localparam int                FW    = $clog2(MAX_TRIES + 1);
   localparam logic [FW:0]       MAX_T = (FW + 1)'(MAX_TRIES);

   pe_state_t      state_q, state_d;
   logic [15:0]    buf_q, buf_d;
   logic [2:0]     cnt_q, cnt_d;
   logic [FW-1:0]  fail_q, fail_d;
   logic [FW:0]    fail_inc;
   logic           pw_valid_q, pw_valid_d;
   logic           idle_start, idle_kick, idle_expire;
   logic           lock_start, lock_expire;

   assign fail_inc  = {1'b0, fail_q} + 1'b1;
   assign idle_kick = key_valid_i && (state_q == ST_COLLECT);

   entry_timer #(.CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .start_i  (idle_start),
      .kick_i   (idle_kick),
      .expire_o (idle_expire)
   );

   entry_timer #(.CYCLES(LOCK_CYCLES)) u_lock_timer (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .start_i  (lock_start),
      .kick_i   (1'b0),
      .expire_o (lock_expire)
   );

   always_comb begin
      state_d    = state_q;
      buf_d      = buf_q;
      cnt_d      = cnt_q;
      fail_d     = fail_q;
      pw_valid_d = 1'b0;
      idle_start = 1'b0;
      lock_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            buf_d = '0;
            cnt_d = '0;
            if (arm_i) begin
               state_d    = ST_COLLECT;
               idle_start = 1'b1;
            end
         end
         ST_COLLECT: begin
            if (key_valid_i) begin
               if (is_digit(key_code_i)) begin
                  if (cnt_q < 3'd4) begin
                     buf_d = {buf_q[11:0], key_code_i};
                     cnt_d = cnt_q + 3'd1;
                  end
               end else if (key_code_i == KEY_BKSP) begin
                  if (cnt_q != 3'd0) begin
                     buf_d = {4'h0, buf_q[15:4]};
                     cnt_d = cnt_q - 3'd1;
                  end
               end else if (key_code_i == KEY_CLEAR) begin
                  buf_d = '0;
                  cnt_d = '0;
               end else if ((key_code_i == KEY_ENTER) && (cnt_q == 3'd4)) begin
                  state_d    = ST_READY;
                  pw_valid_d = 1'b1;
               end
            end else if (idle_expire) begin
               state_d = ST_IDLE;
               buf_d   = '0;
               cnt_d   = '0;
            end
         end
         ST_READY: begin
            if (pw_ok_i) begin
               state_d = ST_IDLE;
               fail_d  = '0;
               buf_d   = '0;
               cnt_d   = '0;
            end else if (pw_wrong_i) begin
               buf_d = '0;
               cnt_d = '0;
               if (fail_inc == MAX_T) begin
                  state_d    = ST_LOCKED;
                  fail_d     = '0;
                  lock_start = 1'b1;
               end else begin
                  state_d    = ST_COLLECT;
                  fail_d     = fail_inc[FW-1:0];
                  idle_start = 1'b1;
               end
            end
         end
         ST_LOCKED: begin
            if (lock_expire) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         buf_q      <= '0;
         cnt_q      <= '0;
         fail_q     <= '0;
         pw_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         buf_q      <= buf_d;
         cnt_q      <= cnt_d;
         fail_q     <= fail_d;
         pw_valid_q <= pw_valid_d;
      end
   end

   assign password_o     = (state_q == ST_READY) ? buf_q : 16'h0000;
   assign pw_valid_o     = pw_valid_q;
   assign entry_active_o = (state_q == ST_COLLECT);
   assign locked_o       = (state_q == ST_LOCKED);
   assign digit_count_o  = cnt_q;

endmodule

// File: tb/tb_password_entry.sv
// Scoreboard bench for password_entry: directed scenarios plus random key
// sequences checked against a digit-queue model of the keypad.
module tb_password_entry;

   localparam int TO = 8;
   localparam int MT = 3;
   localparam int LK = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        arm = 1'b0;
   logic        key_valid = 1'b0;
   logic [3:0]  key_code = 4'h0;
   logic        pw_ok = 1'b0;
   logic        pw_wrong = 1'b0;
   logic [15:0] password_o;
   logic        pw_valid_o, entry_active_o, locked_o;
   logic [2:0]  digit_count_o;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [3:0]  mdl_digits[$];
   int          mdl_fail = 0;
   bit          mdl_ready = 0;
   logic [15:0] exp_pw[$];
   logic [15:0] last_pw = 16'h0;
   bit          pv_prev = 0;

   password_entry #(.TIMEOUT_CYCLES(TO), .MAX_TRIES(MT), .LOCK_CYCLES(LK)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .arm_i          (arm),
      .key_valid_i    (key_valid),
      .key_code_i     (key_code),
      .pw_ok_i        (pw_ok),
      .pw_wrong_i     (pw_wrong),
      .password_o     (password_o),
      .pw_valid_o     (pw_valid_o),
      .entry_active_o (entry_active_o),
      .locked_o       (locked_o),
      .digit_count_o  (digit_count_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] mdl_pw();
      logic [15:0] p = 16'h0;
      foreach (mdl_digits[i]) p = p * 16 + 16'(mdl_digits[i]);
      return p;
   endfunction

   // Monitor: every pw_valid strobe must match the next queued password.
   always @(negedge clk) begin
      if (pw_valid_o) begin
         chk("pw_valid_single_cycle", {31'b0, pv_prev}, 32'd0);
         if (exp_pw.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pw_valid: got password %0h, expected no strobe", password_o);
         end else begin
            chk("password", password_o, exp_pw.pop_front());
         end
      end
      pv_prev = pw_valid_o;
   end

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      chk("reset_outputs", {10'b0, password_o, pw_valid_o, entry_active_o, locked_o, digit_count_o}, 32'd0);
      rst = 1'b0;
      mdl_digits.delete();
      mdl_fail  = 0;
      mdl_ready = 0;
   endtask

   task automatic arm_up();
      arm = 1'b1;
      cyc();
      arm = 1'b0;
      chk("arm_collect", entry_active_o, 1);
      chk("arm_count", digit_count_o, 0);
   endtask

   task automatic press(input logic [3:0] code);
      if (code <= 4'd9) begin
         if (mdl_digits.size() < 4) mdl_digits.push_back(code);
      end else if (code == 4'hB) begin
         if (mdl_digits.size() > 0) void'(mdl_digits.pop_back());
      end else if (code == 4'hA) begin
         mdl_digits.delete();
      end else if (code == 4'hE && mdl_digits.size() == 4) begin
         last_pw = mdl_pw();
         exp_pw.push_back(last_pw);
         mdl_ready = 1;
      end
      key_valid = 1'b1;
      key_code  = code;
      cyc();
      key_valid = 1'b0;
      key_code  = 4'(code + 4'd3);
      if (!mdl_ready) chk("digit_count", digit_count_o, mdl_digits.size());
   endtask

   task automatic verdict(input bit ok, input bit wrong, output bit lk);
      pw_ok    = ok;
      pw_wrong = wrong;
      cyc();
      pw_ok    = 1'b0;
      pw_wrong = 1'b0;
      mdl_digits.delete();
      mdl_ready = 0;
      lk = 0;
      chk("verdict_pw_cleared", password_o, 0);
      if (ok) begin
         mdl_fail = 0;
         chk("ok_to_idle", {entry_active_o, locked_o}, 0);
      end else if (mdl_fail + 1 == MT) begin
         mdl_fail = 0;
         lk = 1;
         chk("wrong_to_locked", {entry_active_o, locked_o}, 2'b01);
      end else begin
         mdl_fail++;
         chk("wrong_to_collect", {entry_active_o, locked_o}, 2'b10);
         chk("wrong_count_cleared", digit_count_o, 0);
      end
   endtask

   task automatic enter_verdict(input bit ok, input bit wrong, output bit lk);
      press(4'hE);
      chk("pw_valid_rise", pw_valid_o, 1);
      chk("ready_not_collect", entry_active_o, 0);
      cyc();
      chk("pw_valid_fall", pw_valid_o, 0);
      chk("pw_held", password_o, last_pw);
      verdict(ok, wrong, lk);
   endtask

   task automatic wait_lock();
      int n = 0;
      while (locked_o && n < 100) begin
         cyc();
         n++;
      end
      chk("lock_length", n, LK);
      chk("after_lock_idle", {entry_active_o, locked_o}, 0);
   endtask

   task automatic wait_timeout();
      int n = 0;
      while (entry_active_o && n < 50) begin
         cyc();
         n++;
      end
      chk("timeout_length", n, TO);
      chk("timeout_count", digit_count_o, 0);
      mdl_digits.delete();
   endtask

   task automatic type4(input logic [15:0] pw);
      for (int i = 3; i >= 0; i--) press(pw[i*4 +: 4]);
   endtask

   initial begin
      bit lk;
      bit in_collect;
      do_reset();

      // normal entry
      arm_up();
      type4(16'h1234);
      enter_verdict(1, 0, lk);

      // edit keys
      arm_up();
      press(4'h1); press(4'h2); press(4'h9); press(4'hB);
      press(4'h3); press(4'h4); press(4'h5);
      enter_verdict(1, 0, lk);
      arm_up();
      press(4'h7); press(4'hA); press(4'hE);
      chk("short_enter_stays", entry_active_o, 1);
      wait_timeout();

      // lockout
      arm_up();
      for (int i = 0; i < MT; i++) begin
         type4(16'h1111);
         enter_verdict(0, 1, lk);
      end
      chk("third_wrong_locks", lk, 1);
      wait_lock();

      // fail_cnt cleared by lockout and by simultaneous verdict
      arm_up();
      type4(16'h1111);
      enter_verdict(0, 1, lk);
      type4(16'h2222);
      enter_verdict(1, 1, lk);
      arm_up();
      for (int i = 0; i < MT - 1; i++) begin
         type4(16'h3333);
         enter_verdict(0, 1, lk);
      end
      type4(16'h4444);
      enter_verdict(1, 0, lk);

      // timeout and last-cycle cancel
      arm_up();
      press(4'h5);
      wait_timeout();
      arm_up();
      press(4'h5);
      repeat (TO - 1) cyc();
      press(4'hF);
      chk("late_key_cancels_timeout", entry_active_o, 1);
      wait_timeout();

      // reset mid-lockout and mid-entry
      arm_up();
      for (int i = 0; i < MT; i++) begin
         type4(16'h9999);
         enter_verdict(0, 1, lk);
      end
      repeat (3) cyc();
      chk("still_locked_cycle4", locked_o, 1);
      do_reset();
      arm_up();
      press(4'h1); press(4'h2); press(4'h3);
      do_reset();
      arm_up();
      type4(16'h1234);
      enter_verdict(1, 0, lk);

      // randomized sessions
      in_collect = 0;
      for (int r = 0; r < 25; r++) begin
         int n;
         int v;
         if (!in_collect) arm_up();
         n = $urandom_range(3, 10);
         for (int k = 0; k < n; k++) begin
            logic [3:0] c;
            c = 4'($urandom_range(0, 15));
            if (c == 4'hE && mdl_digits.size() == 4) c = 4'hB;
            press(c);
         end
         while (mdl_digits.size() < 4) press(4'($urandom_range(0, 9)));
         v = $urandom_range(0, 3);
         case (v)
            0:       enter_verdict(1, 0, lk);
            2:       enter_verdict(1, 1, lk);
            default: enter_verdict(0, 1, lk);
         endcase
         in_collect = (v == 1 || v == 3) && !lk;
         if (lk) wait_lock();
      end

      repeat (3) cyc();
      chk("no_pending_passwords", exp_pw.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/password_entry.md
# password_entry

Keypad front end for the gate controller. It collects four BCD digits per car, supports clear, backspace and enter, and presents a held 16-bit password with a one-cycle valid strobe to the gate FSM. It takes the gate FSM's accept/reject verdict back and, after repeated rejections, locks the keypad out for a fixed time. One instance sits directly upstream of each gate's password input (entry and exit).

## Interface
- TIMEOUT_CYCLES, 1000: key-free cycles in COLLECT before the entry is abandoned; must be ≥ 2.
- MAX_TRIES, 3: consecutive rejections that trigger lockout; must be ≥ 1.
- LOCK_CYCLES, 5000: duration of lockout in cycles; must be ≥ 1.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- arm  in  1  car present at the gate sensor; level input.
- key_valid  in  1  one-cycle strobe marking a key press; already debounced.
- key_code  in  4  0–9 = digit, 0xA = clear, 0xB = backspace, 0xE = enter, other codes ignored.
- pw_ok  in  1  one-cycle verdict from the gate FSM: password accepted.
- pw_wrong  in  1  one-cycle verdict from the gate FSM: password rejected.
- password  out  16  four BCD digits, first-typed digit in [15:12]; nonzero only in READY.
- pw_valid  out  1  one-cycle strobe on the first cycle of READY.
- entry_active  out  1  high while in COLLECT.
- locked  out  1  high while in LOCKED.
- digit_count  out  3  digits currently buffered (0–4).

## Operation
The block is a four-state FSM: IDLE, COLLECT, READY, LOCKED.

- **IDLE**
  - The digit buffer, digit_count and the idle timer are cleared.
  - arm = 1 moves the FSM to COLLECT.
  - Keys are ignored.
- **COLLECT** handles keys as follows:
  - **Digit, count < 4:** buf ← {buf[11:0], key_code}; count + 1.
  - **Digit, count = 4:** ignored.
  - **Backspace, count > 0:** buf ← buf >> 4; count − 1.
  - **Backspace, count = 0:** no effect.
  - **Clear:** buf ← 0; count ← 0.
  - **Enter, count = 4:** move to READY; password ← buf.
  - **Enter, count < 4:** ignored, state unchanged.
  - **Other codes:** ignored.
  - arm is not monitored in COLLECT.
- **READY**
  - password holds the buffer value and pw_valid pulses once.
  - Keys are ignored. The FSM waits for a verdict.
  - pw_ok: move to IDLE and clear fail_cnt.
  - pw_wrong with fail_cnt + 1 < MAX_TRIES: fail_cnt + 1; move to COLLECT with buf and count cleared.
  - pw_wrong with fail_cnt + 1 = MAX_TRIES: move to LOCKED and clear fail_cnt.
  - pw_ok and pw_wrong together: pw_ok wins.
- **LOCKED**
  - Keys, arm and verdicts are ignored.
  - After LOCK_CYCLES cycles the FSM moves to IDLE.
- **fail_cnt**
  - Persists across IDLE.
  - Cleared only by pw_ok, by lockout entry, or by rst.

## Timing
- **Reset:** rst = 1 forces, at the next edge, state IDLE and all outputs 0, overriding every other input. This holds in any state, including mid-lockout and mid-entry.
- **Key latency:** a key accepted at edge N is reflected in digit_count and in the buffer after edge N.
- **Enter:** enter accepted at edge N gives state = READY, password valid and pw_valid = 1 during cycle N+1 only. password stays held until the verdict edge.
- **Verdict:** a verdict sampled at edge M sets the new state after M. password reads 0 from cycle M+1 on.
- **Idle timer:**
  - Reset on COLLECT entry and on every key_valid, including ignored keys.
  - Otherwise increments each COLLECT cycle.
  - After exactly TIMEOUT_CYCLES consecutive key-free COLLECT cycles the FSM returns to IDLE and clears the buffer.
  - A key_valid on the final cycle cancels the timeout.
  - Timeout does not touch fail_cnt.
- **Lock timer:** LOCKED lasts exactly LOCK_CYCLES cycles; locked = 1 for exactly LOCK_CYCLES cycles.
- **Counter widths:**
  - Timers are $clog2(max + 1) bits wide and cannot overflow.
  - fail_cnt is $clog2(MAX_TRIES + 1) bits wide.

## Structure
- **Shared package** holds:
  - the state enum;
  - the key-code constants KEY_CLEAR = 4'hA, KEY_BKSP = 4'hB, KEY_ENTER = 4'hE;
  - the digit-range check helper (key_code ≤ 9).
- **Sub-module:** one natural sub-module, entry_timer.
  - Ports: clk, rst, start, kick, expire; parameter CYCLES.
  - Instanced twice: once for the idle timeout and once for the lockout.
- **FSM, buffer and fail counter** live in the top module.

## Test plan
Bench parameters: TIMEOUT_CYCLES = 8, MAX_TRIES = 3, LOCK_CYCLES = 10.

- **Normal entry:** arm, keys 1, 2, 3, 4, enter → pw_valid for one cycle with password = 16'h1234; pw_ok → IDLE and password = 0 on the next cycle.
- **Edit keys:** keys 1, 2, 9, backspace, 3, 4, 5, enter → password = 16'h1234 (the 5 is ignored at count 4). Keys 7, clear, then enter → ignored, digit_count = 0.
- **Lockout:** three entries of 16'h1111, each answered by pw_wrong → first two return to COLLECT with digit_count = 0; third gives locked = 1 for exactly 10 cycles, then IDLE with fail_cnt = 0.
- **Timeout:** arm, key 5, then no keys → entry_active drops after exactly 8 key-free cycles, digit_count = 0. Repeat with a key on cycle 8 → the FSM stays in COLLECT.
- **Simultaneous verdict:** pw_ok and pw_wrong in the same cycle in READY → IDLE with fail_cnt unchanged at 0.
- **Reset mid-operation:** rst asserted during LOCKED (cycle 4) and during COLLECT with count = 3 → IDLE with all outputs 0 after one edge. A subsequent entry of 1234 works normally.
